// File: rtl/lsu_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_access_ctrl_if
// Brief   : Request/response and word-memory port bundle for lsu_access_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface lsu_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_base;
    logic [31:0]       req_offset;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Execute stage plus memory: issues requests, returns read data
    modport master (
        output req_valid, req_base, req_offset, req_store, req_size,
               req_unsigned, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_base, req_offset, req_store, req_size,
               req_unsigned, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
               mem_addr, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_access_ctrl
// Brief   : Single-outstanding load/store controller for a word-wide memory;
//           sub-word stores by read-modify-write, loads sign/zero-extended.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_access_ctrl #(
    parameter int ADDR_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    lsu_access_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_misalign_q, resp_misalign_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_lo_q, wdata_lo_d;

    logic [31:0] ea;
    logic        ea_unused;
    logic        accept;
    logic        misalign;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign ea        = bus.req_base + bus.req_offset;
    // Byte address bits above the memory window simply alias
    assign ea_unused = ^ea[31:ADDR_W+2];
    assign accept    = bus.req_valid & req_ready_q;
    assign misalign  = (bus.req_size == 2'b11)
                     | ((bus.req_size == 2'b01) & ea[0])
                     | ((bus.req_size == 2'b10) & (ea[1:0] != 2'b00));

    assign rd_byte = 8'(bus.mem_rdata >> {lane_q, 3'b000});
    assign rd_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{~unsigned_q & rd_half[15]}}, rd_half};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merge_val = bus.mem_rdata;
        if (size_q == 2'b00) begin
            merge_val[{lane_q, 3'b000} +: 8] = wdata_lo_q[7:0];
        end else begin
            merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_lo_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        resp_valid_d    = 1'b0;
        resp_misalign_d = 1'b0;
        resp_rdata_d    = 32'h0;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        store_d         = store_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        lane_d          = lane_q;
        wdata_lo_d      = wdata_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d = ea[ADDR_W+1:2];
                    store_d    = bus.req_store;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    lane_d     = ea[1:0];
                    wdata_lo_d = bus.req_wdata[15:0];
                    if (misalign) begin
                        state_d         = ST_RESP;
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                    end else if (bus.req_store && (bus.req_size == 2'b10)) begin
                        state_d     = ST_WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                // Read data is valid this cycle; consume it on the way out
                if (store_q) begin
                    state_d     = ST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_val;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_val;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_misalign_q <= 1'b0;
            resp_rdata_q    <= 32'h0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= 32'h0;
            store_q         <= 1'b0;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            lane_q          <= 2'b00;
            wdata_lo_q      <= 16'h0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_misalign_q <= resp_misalign_d;
            resp_rdata_q    <= resp_rdata_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            store_q         <= store_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            lane_q          <= lane_d;
            wdata_lo_q      <= wdata_lo_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_access_ctrl
// Brief   : Directed and random load/store traffic against a byte-lane model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_access_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic mem_init;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    int          obs_lat, obs_resp_cnt, obs_we_cnt;
    logic [31:0] obs_rdata, obs_we_data;
    logic        obs_mis;
    logic [15:0] obs_we_addr, obs_addr1;

    lsu_access_ctrl_if #(.ADDR_W(16)) bus ();

    lsu_access_ctrl #(.ADDR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A17_C3E1;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'h1);
    endtask

    // One request end to end, checked against a lane/mask model of memory
    task automatic do_req(input logic [31:0] base, input logic [31:0] off, input logic st,
                          input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        logic [31:0] ea, old, nw, mask, exp_rdata, lanev;
        logic [15:0] waddr;
        int          sh, exp_lat;
        logic        mis, exp_we;
        ea        = base + off;
        waddr     = ea[17:2];
        mis       = (sz == 2'b11) || (sz == 2'b01 && ea[0]) || (sz == 2'b10 && ea[1:0] != 2'b00);
        old       = ref_mem[waddr];
        nw        = old;
        exp_rdata = 32'h0;
        exp_we    = 1'b0;
        sh        = (sz == 2'b00) ? int'(ea[1:0]) * 8 : int'(ea[1]) * 16;
        mask      = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        if (mis) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_lat = 3;
            if (sz == 2'b10) begin
                exp_rdata = old;
            end else begin
                lanev     = (old & mask) >> sh;
                exp_rdata = lanev;
                if (!uns && sz == 2'b00 && lanev[7])  exp_rdata = exp_rdata | 32'hFFFF_FF00;
                if (!uns && sz == 2'b01 && lanev[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
            end
        end else begin
            exp_we  = 1'b1;
            exp_lat = (sz == 2'b10) ? 2 : 4;
            nw      = (sz == 2'b10) ? wd : ((old & ~mask) | ((wd << sh) & mask));
            ref_mem[waddr] = nw;
        end

        wait_ready();
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_base     = $urandom;
        bus.req_offset   = $urandom;
        bus.req_store    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_wdata    = $urandom;

        obs_lat = 0; obs_resp_cnt = 0; obs_we_cnt = 0;
        obs_rdata = 32'h0; obs_mis = 1'b0; obs_we_data = 32'h0; obs_we_addr = 16'h0; obs_addr1 = 16'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                obs_addr1 = bus.mem_addr;
                chk("ready_low_busy", 32'(bus.req_ready), 32'h0);
            end
            if (bus.resp_valid) begin
                if (obs_resp_cnt == 0) begin
                    obs_lat   = k;
                    obs_rdata = bus.resp_rdata;
                    obs_mis   = bus.resp_misalign;
                end
                obs_resp_cnt++;
            end
            if (bus.mem_we) begin
                obs_we_cnt++;
                obs_we_addr = bus.mem_addr;
                obs_we_data = bus.mem_wdata;
            end
        end
        chk("resp_latency", 32'(obs_lat), 32'(exp_lat));
        chk("resp_count", 32'(obs_resp_cnt), 32'h1);
        chk("resp_misalign", 32'(obs_mis), 32'(mis));
        chk("resp_rdata", obs_rdata, exp_rdata);
        chk("we_cycles", 32'(obs_we_cnt), 32'(exp_we));
        if (!mis) chk("mem_addr", 32'(obs_addr1), 32'(waddr));
        if (exp_we) begin
            chk("we_addr", 32'(obs_we_addr), 32'(waddr));
            chk("we_data", obs_we_data, nw);
        end
        chk("mem_word", mem[waddr], ref_mem[waddr]);
    endtask

    initial begin
        logic [31:0] r, ea_t, off;
        int          n;
        logic        got_we;
        rst_n            = 1'b0;
        mem_init         = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_base     = 32'h0;
        bus.req_offset   = 32'h0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);

        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_misalign", 32'(bus.resp_misalign), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(bus.req_ready), 32'h1);
        @(negedge clk);

        // Word store, then set up the word used by the sub-word cases
        do_req(32'h100, 32'h4, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF);
        chk("t1_we_addr", 32'(obs_we_addr), 32'h41);
        chk("t1_we_data", obs_we_data, 32'hDEAD_BEEF);
        do_req(32'h100, 32'h4, 1'b1, 2'b10, 1'b0, 32'h1122_3344);
        do_req(32'h100, 32'h6, 1'b1, 2'b00, 1'b0, 32'h0000_00A5);
        chk("t2_merge", obs_we_data, 32'h11A5_3344);
        do_req(32'h100, 32'h6, 1'b0, 2'b00, 1'b0, 32'h0);
        chk("t3_lb_signed", obs_rdata, 32'hFFFF_FFA5);
        do_req(32'h100, 32'h6, 1'b0, 2'b00, 1'b1, 32'h0);
        chk("t3_lb_unsigned", obs_rdata, 32'h0000_00A5);
        do_req(32'h100, 32'h6, 1'b0, 2'b01, 1'b0, 32'h0);
        chk("t3_lh_signed", obs_rdata, 32'h0000_11A5);
        do_req(32'h100, 32'h3, 1'b0, 2'b01, 1'b0, 32'h0);
        chk("t4_misalign_half", 32'(obs_mis), 32'h1);
        do_req(32'h100, 32'h0, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFF);
        chk("t4_size11_we", 32'(obs_we_cnt), 32'h0);
        do_req(32'h108, 32'hFFFF_FFFC, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t5_wrap_addr", 32'(obs_addr1), 32'h41);
        do_req(32'h0004_0100, 32'h4, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("t5_alias_addr", 32'(obs_addr1), 32'h41);
        chk("t5_alias_data", obs_rdata, 32'h11A5_3344);
        do_req(32'h100, 32'h7, 1'b1, 2'b00, 1'b0, 32'hFFFF_FF5A);
        do_req(32'h100, 32'h6, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF);
        do_req(32'h100, 32'h4, 1'b0, 2'b01, 1'b1, 32'h0);

        // Reset while the sub-word write is on the bus
        wait_ready();
        bus.req_base = 32'h108; bus.req_offset = 32'h5; bus.req_store = 1'b1;
        bus.req_size = 2'b00;   bus.req_unsigned = 1'b0; bus.req_wdata = 32'h77;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        got_we = 1'b0;
        n = 0;
        while (!got_we && n < 6) begin
            @(negedge clk);
            got_we = bus.mem_we;
            n++;
        end
        chk("t6_reached_wr", 32'(got_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_we_drop", 32'(bus.mem_we), 32'h0);
        chk("t6_ready_low", 32'(bus.req_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_no_resp", 32'(bus.resp_valid), 32'h0);
        end
        chk("t6_word_kept", mem[16'h43], ref_mem[16'h43]);
        rst_n = 1'b1;
        #1;
        chk("t6_ready_pre_edge", 32'(bus.req_ready), 32'h0);
        chk("t6_no_resp_rel", 32'(bus.resp_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("t6_ready_post_edge", 32'(bus.req_ready), 32'h1);
        @(negedge clk);

        // Random traffic over a small window with aliased upper address bits
        for (int t = 0; t < 250; t++) begin
            r    = $urandom;
            ea_t = (r & 32'hFFFC_0000) | 32'($urandom_range(0, 63));
            off  = ((t % 3) == 0) ? 32'($urandom_range(0, 16)) : $urandom;
            do_req(ea_t - off, off, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
